// File: rtl/pg_operand_stage_if.sv
// Operand/result bundle between the upstream issuer, the operand stage and the
// carry-lookahead units.
interface pg_operand_stage_if #(
   parameter int WIDTH = 16,
   parameter int TAGW  = 4
);
   localparam int NG = WIDTH / 4;

   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] P;
   logic [WIDTH-1:0] G;
   logic [NG-1:0]    GP;
   logic [NG-1:0]    GG;
   logic             C0;
   logic [TAGW-1:0]  TAG;

   modport master (
      output IN_VALID, A, B, CIN, OUT_READY,
      input  IN_READY, OUT_VALID, P, G, GP, GG, C0, TAG
   );

   modport slave (
      input  IN_VALID, A, B, CIN, OUT_READY,
      output IN_READY, OUT_VALID, P, G, GP, GG, C0, TAG
   );
endinterface

// File: rtl/pg_operand_stage.sv
// Operand front end of the adder: 2-entry operand buffer with valid/ready handshake,
// presenting registered propagate/generate terms of the head entry to the CLUs.
module pg_operand_stage #(
   parameter int WIDTH = 16,
   parameter int TAGW  = 4
) (
   input  logic               PHI,
   input  logic               RST_,
   pg_operand_stage_if.slave  bus
);
   localparam int NG = WIDTH / 4;
   // Entry layout: {tag, cin, b, a}
   localparam int EW = 2 * WIDTH + 1 + TAGW;

   logic [EW-1:0]    r_ent0;
   logic [EW-1:0]    r_ent1;
   logic [1:0]       r_cnt;
   logic [TAGW-1:0]  r_tag_ctr;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_g;
   logic [NG-1:0]    r_gp;
   logic [NG-1:0]    r_gg;
   logic             r_c0;
   logic [TAGW-1:0]  r_tag;

   logic [EW-1:0]    w_new;
   logic [EW-1:0]    w_ent0_nxt;
   logic [EW-1:0]    w_ent1_nxt;
   logic [1:0]       w_cnt_nxt;
   logic             w_push;
   logic             w_pop;
   logic             w_valid_nxt;
   logic [WIDTH-1:0] w_a_nxt;
   logic [WIDTH-1:0] w_b_nxt;
   logic [WIDTH-1:0] w_p_nxt;
   logic [WIDTH-1:0] w_g_nxt;
   logic [NG-1:0]    w_gp_nxt;
   logic [NG-1:0]    w_gg_nxt;
   logic             w_c0_nxt;
   logic [TAGW-1:0]  w_tag_nxt;

   function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   assign w_push = bus.IN_VALID & r_in_ready;
   assign w_pop  = r_out_valid & bus.OUT_READY;
   assign w_new  = {r_tag_ctr, bus.CIN, bus.B, bus.A};

   // Buffer next state: pops shift entry 1 down so entry 0 is always the head
   always_comb begin
      w_ent0_nxt = r_ent0;
      w_ent1_nxt = r_ent1;
      w_cnt_nxt  = r_cnt;
      case ({w_push, w_pop})
         2'b10: begin
            if (r_cnt == 2'd0) begin
               w_ent0_nxt = w_new;
            end else begin
               w_ent1_nxt = w_new;
            end
            w_cnt_nxt = r_cnt + 2'd1;
         end
         2'b01: begin
            w_ent0_nxt = r_ent1;
            w_ent1_nxt = '0;
            w_cnt_nxt  = r_cnt - 2'd1;
         end
         2'b11: begin
            if (r_cnt == 2'd1) begin
               w_ent0_nxt = w_new;
            end else begin
               w_ent0_nxt = r_ent1;
               w_ent1_nxt = w_new;
            end
         end
         default: begin
            w_cnt_nxt = r_cnt;
         end
      endcase
   end

   assign w_valid_nxt = (w_cnt_nxt != 2'd0);
   assign w_a_nxt     = w_ent0_nxt[WIDTH-1:0];
   assign w_b_nxt     = w_ent0_nxt[2*WIDTH-1:WIDTH];

   // Decode the next head entry so the P/G outputs come straight from flops
   always_comb begin
      w_p_nxt   = '0;
      w_g_nxt   = '0;
      w_gp_nxt  = '0;
      w_gg_nxt  = '0;
      w_c0_nxt  = 1'b0;
      w_tag_nxt = r_tag;
      if (w_valid_nxt) begin
         w_p_nxt   = w_a_nxt ^ w_b_nxt;
         w_g_nxt   = w_a_nxt & w_b_nxt;
         w_c0_nxt  = w_ent0_nxt[2*WIDTH];
         w_tag_nxt = w_ent0_nxt[EW-1 -: TAGW];
         for (int k = 0; k < NG; k++) begin
            w_gp_nxt[k] = &w_p_nxt[4*k +: 4];
            w_gg_nxt[k] = grp_gen(w_p_nxt[4*k +: 4], w_g_nxt[4*k +: 4]);
         end
      end else begin
         w_tag_nxt = r_tag;
      end
   end

   // Buffer, counters and registered outputs
   always_ff @(posedge PHI or negedge RST_) begin
      if (!RST_) begin
         r_ent0      <= '0;
         r_ent1      <= '0;
         r_cnt       <= 2'd0;
         r_tag_ctr   <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_p         <= '0;
         r_g         <= '0;
         r_gp        <= '0;
         r_gg        <= '0;
         r_c0        <= 1'b0;
         r_tag       <= '0;
      end else begin
         r_ent0      <= w_ent0_nxt;
         r_ent1      <= w_ent1_nxt;
         r_cnt       <= w_cnt_nxt;
         r_tag_ctr   <= w_push ? r_tag_ctr + {{(TAGW-1){1'b0}}, 1'b1} : r_tag_ctr;
         r_in_ready  <= (w_cnt_nxt != 2'd2);
         r_out_valid <= w_valid_nxt;
         r_p         <= w_p_nxt;
         r_g         <= w_g_nxt;
         r_gp        <= w_gp_nxt;
         r_gg        <= w_gg_nxt;
         r_c0        <= w_c0_nxt;
         r_tag       <= w_tag_nxt;
      end
   end

   assign bus.IN_READY  = r_in_ready;
   assign bus.OUT_VALID = r_out_valid;
   assign bus.P         = r_p;
   assign bus.G         = r_g;
   assign bus.GP        = r_gp;
   assign bus.GG        = r_gg;
   assign bus.C0        = r_c0;
   assign bus.TAG       = r_tag;
endmodule

// File: tb/tb_pg_operand_stage.sv
// Self-checking bench for pg_operand_stage: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_pg_operand_stage;
   localparam int VW = 47;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [3:0]  tag;
   } ent_t;

   logic PHI = 1'b0;
   logic RST_ = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   ent_t       q[$];
   logic       m_ready = 1'b0;
   logic [3:0] m_tag = 4'd0;
   logic [3:0] m_last_tag = 4'd0;

   pg_operand_stage_if #(.WIDTH(16), .TAGW(4)) bus();

   pg_operand_stage #(.WIDTH(16), .TAGW(4)) dut (
      .PHI  (PHI),
      .RST_ (RST_),
      .bus  (bus)
   );

   always #5 PHI = ~PHI;

   function automatic logic [VW-1:0] obs_vec();
      return {bus.OUT_VALID, bus.IN_READY, bus.P, bus.G, bus.GP, bus.GG, bus.C0, bus.TAG};
   endfunction

   // Expected outputs from the model: group terms via 4-bit addition carry-out
   function automatic logic [VW-1:0] exp_vec();
      logic [15:0] p = 16'h0;
      logic [15:0] g = 16'h0;
      logic [3:0]  gp = 4'h0;
      logic [3:0]  gg = 4'h0;
      logic        c0 = 1'b0;
      logic        v;
      logic [4:0]  s;
      v = (q.size() != 0);
      if (v) begin
         p  = q[0].a ^ q[0].b;
         g  = q[0].a & q[0].b;
         c0 = q[0].cin;
         for (int k = 0; k < 4; k++) begin
            gp[k] = (p[4*k +: 4] == 4'hF);
            s     = {1'b0, q[0].a[4*k +: 4]} + {1'b0, q[0].b[4*k +: 4]};
            gg[k] = s[4];
         end
      end
      return {v, m_ready, p, g, gp, gg, c0, m_last_tag};
   endfunction

   task automatic model_reset();
      q.delete();
      m_ready    = 1'b0;
      m_tag      = 4'd0;
      m_last_tag = 4'd0;
   endtask

   task automatic tick(input logic iv, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic ordy);
      logic push;
      logic pop;
      ent_t e;
      bus.IN_VALID  = iv;
      bus.A         = a;
      bus.B         = b;
      bus.CIN       = cin;
      bus.OUT_READY = ordy;
      @(posedge PHI);
      if (RST_) begin
         push = iv && m_ready;
         pop  = (q.size() != 0) && ordy;
         if (pop) q.delete(0);
         if (push) begin
            e.a = a; e.b = b; e.cin = cin; e.tag = m_tag;
            q.push_back(e);
            m_tag = m_tag + 4'd1;
         end
         m_ready = (q.size() != 2);
         if (q.size() != 0) m_last_tag = q[0].tag;
      end
      @(negedge PHI);
   endtask

   task automatic apply_reset();
      RST_ = 1'b0;
      model_reset();
      #2;
      RST_ = 1'b1;
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      RST_ = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         n_cmp++;
         if (obs_vec() !== {VW{1'b0}}) begin
            $display("FAIL reset_zero: got %h exp %h", obs_vec(), {VW{1'b0}});
            n_fail++;
         end
      end
      RST_ = 1'b1;
      #1;
      n_cmp++;
      if (bus.IN_READY !== 1'b0) begin
         $display("FAIL reset_ready_before_edge: got %b exp 0", bus.IN_READY);
         n_fail++;
      end
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.IN_READY !== 1'b1 || obs_vec() !== exp_vec()) begin
         $display("FAIL reset_release: got %h exp %h", obs_vec(), exp_vec());
         n_fail++;
      end
   endtask

   task automatic test_single_op();
      tick(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec() !== {1'b1, 1'b1, 16'h00FE, 16'h0001, 4'b0010, 4'b0001, 1'b0, 4'd0}) begin
         $display("FAIL single_op: got %h exp %h", obs_vec(),
                  {1'b1, 1'b1, 16'h00FE, 16'h0001, 4'b0010, 4'b0001, 1'b0, 4'd0});
         n_fail++;
      end
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         $display("FAIL single_op_drain: got %h exp %h", obs_vec(), exp_vec());
         n_fail++;
      end
   endtask

   task automatic test_full_propagate();
      tick(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
      n_cmp++;
      if (obs_vec() !== {1'b1, 1'b1, 16'hFFFF, 16'h0000, 4'b1111, 4'b0000, 1'b1, 4'd1}) begin
         $display("FAIL full_propagate: got %h exp %h", obs_vec(),
                  {1'b1, 1'b1, 16'hFFFF, 16'h0000, 4'b1111, 4'b0000, 1'b1, 4'd1});
         n_fail++;
      end
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [15:0] av[3];
      logic [15:0] bv[3];
      logic [VW-1:0] held;
      for (int i = 0; i < 3; i++) begin
         av[i] = 16'($urandom);
         bv[i] = 16'($urandom);
      end
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, av[i], bv[i], 1'b0, 1'b0);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL bp_fill%0d: got %h exp %h", i, obs_vec(), exp_vec());
            n_fail++;
         end
      end
      held = obs_vec();
      tick(1'b1, av[2], bv[2], 1'b0, 1'b0);
      n_cmp++;
      if (bus.IN_READY !== 1'b0 || bus.TAG !== 4'd0 || obs_vec() !== held) begin
         $display("FAIL bp_hold: got %h exp %h", obs_vec(), held);
         n_fail++;
      end
      tick(1'b1, av[2], bv[2], 1'b0, 1'b1);
      n_cmp++;
      if (bus.TAG !== 4'd1 || bus.P !== (av[1] ^ bv[1]) || obs_vec() !== exp_vec()) begin
         $display("FAIL bp_pop1: got %h exp %h", obs_vec(), exp_vec());
         n_fail++;
      end
      tick(1'b1, av[2], bv[2], 1'b0, 1'b1);
      n_cmp++;
      if (bus.TAG !== 4'd2 || bus.P !== (av[2] ^ bv[2]) || obs_vec() !== exp_vec()) begin
         $display("FAIL bp_third: got %h exp %h", obs_vec(), exp_vec());
         n_fail++;
      end
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
   endtask

   task automatic test_streaming();
      logic [3:0] prev;
      logic       wrapped = 1'b0;
      apply_reset();
      prev = bus.TAG;
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
         n_cmp++;
         if (bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b1 || obs_vec() !== exp_vec()) begin
            $display("FAIL stream%0d: got %h exp %h", i, obs_vec(), exp_vec());
            n_fail++;
         end
         if (prev == 4'd15 && bus.TAG == 4'd0) wrapped = 1'b1;
         prev = bus.TAG;
      end
      n_cmp++;
      if (wrapped !== 1'b1) begin
         $display("FAIL stream_tag_wrap: got %b exp 1", wrapped);
         n_fail++;
      end
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         tick(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL random%0d: got %h exp %h", i, obs_vec(), exp_vec());
            n_fail++;
         end
      end
   endtask

   task automatic test_mid_reset();
      tick(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      tick(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      tick(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      n_cmp++;
      if (bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0) begin
         $display("FAIL mid_reset_full: got v=%b r=%b exp v=1 r=0", bus.OUT_VALID, bus.IN_READY);
         n_fail++;
      end
      #2;
      RST_ = 1'b0;
      #1;
      n_cmp++;
      if (obs_vec() !== {VW{1'b0}}) begin
         $display("FAIL mid_reset_async: got %h exp %h", obs_vec(), {VW{1'b0}});
         n_fail++;
      end
      model_reset();
      RST_ = 1'b1;
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
      n_cmp++;
      if (bus.TAG !== 4'd0 || obs_vec() !== exp_vec()) begin
         $display("FAIL mid_reset_tag: got %h exp %h", obs_vec(), exp_vec());
         n_fail++;
      end
   endtask

   initial begin
      bus.IN_VALID  = 1'b0;
      bus.A         = 16'h0;
      bus.B         = 16'h0;
      bus.CIN       = 1'b0;
      bus.OUT_READY = 1'b0;
      @(negedge PHI);
      test_reset();
      test_single_op();
      test_full_propagate();
      test_backpressure();
      test_streaming();
      test_random();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
